// File: rtl/valu_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | valu_sequencer                                                             |
// | Round-robin shares one LANES-wide pipelined VALU between two requesters,   |
// | streams each vector op as beats and merges masked results.                 |
// | Optional macro: VALU_SEQ_SKIP_MASKED_EN (skip beats whose mask is all 0).  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module valu_sequencer #(
    parameter int NUM_ELEMENTS = 16,
    parameter int LANES        = 4,
    parameter int ELEM_W       = 16,
    parameter int OPC_W        = 4,
    parameter int VALU_LAT     = 2
) (
    input  logic                               CLK,
    input  logic                               nRST,
    input  logic [1:0]                         req_valid,
    output logic [1:0]                         req_ready,
    input  logic [2*NUM_ELEMENTS*ELEM_W-1:0]   req_vdat1,
    input  logic [2*NUM_ELEMENTS*ELEM_W-1:0]   req_vdat2,
    input  logic [2*OPC_W-1:0]                 req_vop,
    input  logic [2*NUM_ELEMENTS-1:0]          req_vmask,
    output logic                               valu_valid,
    output logic [LANES*ELEM_W-1:0]            valu_vdat1,
    output logic [LANES*ELEM_W-1:0]            valu_vdat2,
    output logic [OPC_W-1:0]                   valu_vop,
    output logic [LANES-1:0]                   valu_vmask,
    input  logic [LANES*ELEM_W-1:0]            valu_result,
    output logic                               rsp_valid,
    input  logic                               rsp_ready,
    output logic                               rsp_id,
    output logic [NUM_ELEMENTS*ELEM_W-1:0]     rsp_result,
    output logic                               busy
);

    localparam int BEATS  = NUM_ELEMENTS / LANES;
    localparam int BIDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CNT_W  = $clog2(BEATS + 1);
    localparam int VEC_W  = NUM_ELEMENTS * ELEM_W;
    localparam int BEAT_W = LANES * ELEM_W;

    localparam logic [BIDX_W-1:0] LAST_BEAT = BIDX_W'(BEATS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]              state_q, state_d;
    logic                    ptr_q, ptr_d;
    logic                    id_q;
    logic [VEC_W-1:0]        vdat1_q, vdat2_q, buf_q;
    logic [OPC_W-1:0]        vop_q;
    logic [NUM_ELEMENTS-1:0] vmask_q;
    logic [BIDX_W-1:0]       beat_q, beat_d;
    logic [CNT_W-1:0]        iss_cnt_q, iss_cnt_d;
    logic [CNT_W-1:0]        cap_cnt_q, cap_cnt_d;
    logic [VALU_LAT-1:0]     pipe_vld_q;
    logic [BIDX_W-1:0]       pipe_idx_q [VALU_LAT];

    logic                    w_grant;
    logic                    w_req_hs;
    logic                    w_skip;
    logic                    w_last;
    logic                    w_issue_fire;
    logic                    w_cap;
    logic [BIDX_W-1:0]       w_cap_idx;

    // Pointer only matters when both requesters compete.
    always_comb begin
        w_grant = 1'b0;
        if (req_valid == 2'b11) begin
            w_grant = ptr_q;
        end else if (req_valid[1]) begin
            w_grant = 1'b1;
        end
    end

    assign w_req_hs  = (state_q == S_IDLE) && (|req_valid);
    assign req_ready = w_req_hs ? {w_grant, ~w_grant} : 2'b00;

`ifdef VALU_SEQ_SKIP_MASKED_EN
    logic [BEATS-1:0] w_beat_live;
    logic [BEATS-1:0] w_live_above;

    for (genvar k = 0; k < BEATS; k++) begin : g_live
        assign w_beat_live[k] = |vmask_q[k*LANES +: LANES];
    end

    // Leave ISSUE as soon as no live beat remains beyond the current one.
    assign w_live_above = w_beat_live >> (32'(beat_q) + 32'd1);
    assign w_skip       = ~w_beat_live[beat_q];
    assign w_last       = (beat_q == LAST_BEAT) || (w_live_above == '0);
`else
    assign w_skip = 1'b0;
    assign w_last = (beat_q == LAST_BEAT);
`endif

    assign w_issue_fire = (state_q == S_ISSUE) && !w_skip;
    assign w_cap        = pipe_vld_q[VALU_LAT-1];
    assign w_cap_idx    = pipe_idx_q[VALU_LAT-1];

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        beat_d    = beat_q;
        iss_cnt_d = iss_cnt_q + CNT_W'(w_issue_fire);
        cap_cnt_d = cap_cnt_q + CNT_W'(w_cap);
        case (state_q)
            S_IDLE: begin
                if (w_req_hs) begin
                    state_d   = S_ISSUE;
                    ptr_d     = ~w_grant;
                    beat_d    = '0;
                    iss_cnt_d = '0;
                    cap_cnt_d = '0;
                end
            end
            S_ISSUE: begin
                beat_d = beat_q + 1'b1;
                if (w_last) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (cap_cnt_d == iss_cnt_q) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (nRST) begin
            state_q    <= S_IDLE;
            ptr_q      <= 1'b0;
            id_q       <= 1'b0;
            vdat1_q    <= '0;
            vdat2_q    <= '0;
            vop_q      <= '0;
            vmask_q    <= '0;
            beat_q     <= '0;
            iss_cnt_q  <= '0;
            cap_cnt_q  <= '0;
            buf_q      <= '0;
            pipe_vld_q <= '0;
            for (int s = 0; s < VALU_LAT; s++) begin
                pipe_idx_q[s] <= '0;
            end
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            beat_q    <= beat_d;
            iss_cnt_q <= iss_cnt_d;
            cap_cnt_q <= cap_cnt_d;
            if (w_req_hs) begin
                id_q    <= w_grant;
                vdat1_q <= req_vdat1[w_grant*VEC_W +: VEC_W];
                vdat2_q <= req_vdat2[w_grant*VEC_W +: VEC_W];
                vop_q   <= req_vop[w_grant*OPC_W +: OPC_W];
                vmask_q <= req_vmask[w_grant*NUM_ELEMENTS +: NUM_ELEMENTS];
            end
            // Tag pipeline mirrors the VALU latency so each return finds its slice.
            pipe_vld_q[0] <= w_issue_fire;
            pipe_idx_q[0] <= beat_q;
            for (int s = 1; s < VALU_LAT; s++) begin
                pipe_vld_q[s] <= pipe_vld_q[s-1];
                pipe_idx_q[s] <= pipe_idx_q[s-1];
            end
            if (w_cap) begin
                buf_q[w_cap_idx*BEAT_W +: BEAT_W] <= valu_result;
            end
            if ((state_q == S_ISSUE) && w_skip) begin
                buf_q[beat_q*BEAT_W +: BEAT_W] <= vdat1_q[beat_q*BEAT_W +: BEAT_W];
            end
        end
    end

    always_comb begin
        valu_valid = w_issue_fire;
        valu_vdat1 = '0;
        valu_vdat2 = '0;
        valu_vop   = '0;
        valu_vmask = '0;
        if (state_q == S_ISSUE) begin
            valu_vdat1 = vdat1_q[beat_q*BEAT_W +: BEAT_W];
            valu_vdat2 = vdat2_q[beat_q*BEAT_W +: BEAT_W];
            valu_vop   = vop_q;
            valu_vmask = vmask_q[beat_q*LANES +: LANES];
        end
    end

    // Masked-off elements always come from operand 1, never from the VALU.
    always_comb begin
        rsp_result = '0;
        if (state_q == S_RESP) begin
            for (int j = 0; j < NUM_ELEMENTS; j++) begin
                rsp_result[j*ELEM_W +: ELEM_W] = vmask_q[j] ? buf_q[j*ELEM_W +: ELEM_W]
                                                            : vdat1_q[j*ELEM_W +: ELEM_W];
            end
        end
    end

    assign rsp_valid = (state_q == S_RESP);
    assign rsp_id    = (state_q == S_RESP) ? id_q : 1'b0;
    assign busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: doc/valu_sequencer.md
Name: valu_sequencer

Overview:
- Shares one LANES-wide, fixed-latency, pipelined VALU between two vector requesters: requester 0 is the scheduler issue path, requester 1 is the swizzle/reduction path.
- Round-robin arbitrates between the two, latches the granted full-width vector op, and streams it through the VALU as NUM_ELEMENTS/LANES beats.
- Collects the returning beats into a result buffer, applies merge-masking, and returns the full vector result tagged with the requester id.

Parameters:
- NUM_ELEMENTS, 16, elements per vector register.
- LANES, 4, VALU datapath width in elements. NUM_ELEMENTS % LANES == 0 is required.
- ELEM_W, 16, element width (FP16).
- OPC_W, 4, opcode width. Passed through to the VALU unchanged.
- VALU_LAT, 2, VALU pipeline latency in cycles. Must be >= 1.

Ports:
- CLK  in  1  clock; all logic is rising-edge.
- nRST  in  1  reset; synchronous, active-high (1 = reset).
- req_valid  in  2  per-requester op valid; bit i belongs to requester i.
- req_ready  out  2  per-requester accept.
- req_vdat1  in  2*NUM_ELEMENTS*ELEM_W  operand 1; requester i occupies slice i.
- req_vdat2  in  2*NUM_ELEMENTS*ELEM_W  operand 2; requester i occupies slice i.
- req_vop  in  2*OPC_W  opcode; requester i occupies slice i.
- req_vmask  in  2*NUM_ELEMENTS  element mask; requester i occupies slice i.
- valu_valid  out  1  beat issued to the VALU this cycle.
- valu_vdat1  out  LANES*ELEM_W  beat operand 1.
- valu_vdat2  out  LANES*ELEM_W  beat operand 2.
- valu_vop  out  OPC_W  beat opcode.
- valu_vmask  out  LANES  beat mask.
- valu_result  in  LANES*ELEM_W  VALU output; valid exactly VALU_LAT cycles after the matching valu_valid.
- rsp_valid  out  1  full result ready.
- rsp_ready  in  1  consumer accepts the result.
- rsp_id  out  1  requester that owns the result.
- rsp_result  out  NUM_ELEMENTS*ELEM_W  merged result vector.
- busy  out  1  FSM is not in IDLE.

Behaviour:
- BEATS = NUM_ELEMENTS/LANES. Beat k covers elements k*LANES .. k*LANES+LANES-1.
- Reset: FSM goes to IDLE and the round-robin pointer is set to 0. req_ready, valu_valid, rsp_valid and busy are driven 0. valu_* data, rsp_result and rsp_id are driven 0. Any in-flight beats are discarded.
- A reset arriving mid-operation behaves identically: the next cycle is IDLE, and VALU results still returning are ignored.
- States and transitions:
  - IDLE: req_ready is nonzero only here, with exactly one bit set, combinationally, for the granted requester.
    - Grant is given to the single valid requester. If both are valid, the grant goes to the requester the pointer designates.
    - On handshake: latch that requester's vdat1, vdat2, vop and vmask; latch id; set the pointer to the other requester; go to ISSUE.
  - ISSUE: drive beat k = 0..BEATS-1 on consecutive cycles with valu_valid=1. valu_vop and valu_vmask are constant across the operation. After the last beat, go to DRAIN.
  - DRAIN: valu_valid=0. Wait until all BEATS results have been captured, then go to RESP.
  - RESP: rsp_valid=1. rsp_result, rsp_id and rsp_result stay stable until rsp_ready. On handshake, go to IDLE, so there is one bubble cycle between operations. rsp_ready held low stalls indefinitely with no state change.
- Capture: a VALU_LAT-deep shift register carries {valid, beat index}. When the delayed entry is valid, valu_result is written into buffer slice [index].
  - Capture is also active during the ISSUE overlap, since beat 0 can return before the last beat issues when VALU_LAT < BEATS.
- Merge: element j of rsp_result = VALU result if vmask[j]=1, else latched vdat1[j]. A mask-0 element is never taken from the VALU.
- Latency: request handshake at edge t gives beat 0 in cycle t+1 and rsp_valid in cycle t+BEATS+VALU_LAT+1. With defaults that is 7 cycles.
- Simultaneous events: a new req_valid during ISSUE, DRAIN or RESP is not accepted (req_ready=0). The requester holds its request, and the pointer decides once the FSM reaches IDLE.
- Opcode: passed through unmodified; the block does not interpret it.

Optional Feature:
- Macro VALU_SEQ_SKIP_MASKED_EN.
- Defined:
  - A beat whose LANES mask bits are all 0 is not issued. The FSM advances to the next beat that cycle with valu_valid=0, and that beat's buffer slice is filled from vdat1 on the same edge.
  - DRAIN waits only for the issued beats.
  - An all-zero vmask goes ISSUE -> DRAIN -> RESP with no VALU activity. rsp_valid asserts at t+BEATS+1 or earlier, and never later than the unskipped latency.
- Undefined: all BEATS beats are always issued, whatever the mask.

Test Plan:
- Single op: req0 with vdat1[j]=j, vdat2[j]=1 and vmask all 1s; the bench VALU model adds integer-wise with VALU_LAT=2. Required: beats issued in cycles t+1..t+4, rsp_valid at t+7, rsp_id=0, rsp_result[j]=j+1.
- Contention: both requesters valid in the same cycle from reset. Required: grant 0 first, then grant 1 on the next IDLE. With both held continuously, grants alternate 0,1,0,1.
- Mask merge: vmask=0x00FF on the above op. Required: elements 0-7 = j+1, elements 8-15 = j.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid. Required: rsp_result and rsp_id are stable throughout, req_ready=0 throughout, and the FSM returns to IDLE the cycle after rsp_ready=1.
- Reset mid-ISSUE: assert nRST at beat 2. Required: next cycle all outputs 0, busy=0, and later VALU returns are ignored. A subsequent op produces a correct result.
- With VALU_SEQ_SKIP_MASKED_EN: vmask=0x0F0F. Required: only beats 0 and 2 assert valu_valid, and results are correct. With vmask=0, valu_valid never asserts and rsp_result=vdat1.
